// File: rtl/dmem_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_bus_pkg
//  Purpose  : Shared size encodings, FSM states and alignment helper for the
//             data-memory bus master.
//  Revision : 1.0  initial release
// ============================================================================
package dmem_bus_pkg;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } dmem_state_t;

    // Encoding 2'b11 is treated as a byte access, which is never misaligned
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_WORD: is_misaligned = (addr_lo != 2'b00);
            SIZE_HALF: is_misaligned = addr_lo[0];
            default:   is_misaligned = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_bus_master_if.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_bus_master_if
//  Purpose  : Pipeline request/response channel plus the external memory bus
//             control/address pins (the tristate data pins stay a plain port).
//  Revision : 1.0  initial release
// ============================================================================
interface dmem_bus_master_if #(
    parameter int BIT_WIDTH = 32
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [1:0]           req_size;
    logic                 req_signed;
    logic [BIT_WIDTH-1:0] req_addr;
    logic [BIT_WIDTH-1:0] req_wdata;
    logic                 rsp_valid;
    logic [BIT_WIDTH-1:0] rsp_rdata;
    logic                 rsp_err;
    logic [BIT_WIDTH-1:0] DAD;
    logic                 MREQ;
    logic                 WRITE;
    logic [1:0]           SIZE;
    logic                 ACKD_n;

    modport master (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, ACKD_n,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, DAD, MREQ, WRITE, SIZE
    );

    modport slave (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, ACKD_n,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, DAD, MREQ, WRITE, SIZE
    );

endinterface
`default_nettype wire

// File: rtl/dmem_load_ext.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_load_ext
//  Purpose  : Combinational size selection and sign/zero extension of the
//             data word captured from the bus during a load.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_load_ext
    import dmem_bus_pkg::*;
#(
    parameter int BIT_WIDTH = 32
) (
    input  logic [BIT_WIDTH-1:0] i_data,
    input  logic [1:0]           i_size,
    input  logic                 i_signed,
    output logic [BIT_WIDTH-1:0] o_data
);

    always_comb begin
        o_data = i_data;
        case (i_size)
            SIZE_WORD: o_data = i_data;
            SIZE_HALF: o_data = {{(BIT_WIDTH-16){i_signed & i_data[15]}}, i_data[15:0]};
            default:   o_data = {{(BIT_WIDTH-8){i_signed & i_data[7]}}, i_data[7:0]};
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_bus_master.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_bus_master
//  Purpose  : Single-outstanding load/store initiator for the external data
//             memory bus; optional ACKD_n timeout via DMEM_TIMEOUT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_bus_master
    import dmem_bus_pkg::*;
#(
    parameter int BIT_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    dmem_bus_master_if.master    bus,
    inout  wire  [BIT_WIDTH-1:0] DDT
);

    dmem_state_t          r_state;
    dmem_state_t          w_state_nxt;
    logic [BIT_WIDTH-1:0] r_addr;
    logic [BIT_WIDTH-1:0] r_wdata;
    logic [BIT_WIDTH-1:0] r_rdata;
    logic [1:0]           r_size;
    logic                 r_write;
    logic                 r_signed;
    logic [BIT_WIDTH-1:0] w_wdata_bus;
    logic [BIT_WIDTH-1:0] w_ext_data;
    logic                 w_misaligned;
    logic                 w_accept;
    logic                 w_capture;
    logic                 w_timeout;
    logic                 w_in_bus;
    logic                 w_ready;
    logic                 w_rsp_valid;
    logic                 w_rsp_err;
    logic                 w_drive;

    assign w_misaligned = is_misaligned(bus.req_size, bus.req_addr[1:0]);
    assign w_accept     = bus.req_valid && w_ready;
    assign w_capture    = (r_state == ST_BUS) && !bus.ACKD_n && !r_write;

`ifdef DMEM_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] r_to_cnt;

    always_ff @(posedge clk) begin
        if (!rst || (r_state != ST_BUS)) begin
            r_to_cnt <= '0;
        end else if (bus.ACKD_n) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign w_timeout = bus.ACKD_n && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (TIMEOUT_CYCLES != 0);
    assign w_timeout    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // DONE and ERR also accept, so a new access can start the edge the response retires
    always_comb begin
        w_state_nxt = r_state;
        w_in_bus    = 1'b0;
        w_ready     = 1'b0;
        w_rsp_valid = 1'b0;
        w_rsp_err   = 1'b0;
        case (r_state)
            ST_BUS: begin
                w_in_bus = 1'b1;
                if (!bus.ACKD_n) begin
                    w_state_nxt = ST_DONE;
                end else if (w_timeout) begin
                    w_state_nxt = ST_ERR;
                end
            end
            default: begin
                w_ready     = 1'b1;
                w_rsp_valid = (r_state == ST_DONE) || (r_state == ST_ERR);
                w_rsp_err   = (r_state == ST_ERR);
                if (bus.req_valid) begin
                    w_state_nxt = w_misaligned ? ST_ERR : ST_BUS;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_size   <= SIZE_WORD;
            r_write  <= 1'b0;
            r_signed <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr   <= bus.req_addr;
                r_wdata  <= bus.req_wdata;
                r_size   <= bus.req_size;
                r_write  <= bus.req_write;
                r_signed <= bus.req_signed;
            end
            if (w_capture) begin
                r_rdata <= DDT;
            end
        end
    end

    // Stores go out right-aligned; the memory performs any lane swizzling
    always_comb begin
        w_wdata_bus = '0;
        case (r_size)
            SIZE_WORD: w_wdata_bus       = r_wdata;
            SIZE_HALF: w_wdata_bus[15:0] = r_wdata[15:0];
            default:   w_wdata_bus[7:0]  = r_wdata[7:0];
        endcase
    end

    dmem_load_ext #(
        .BIT_WIDTH (BIT_WIDTH)
    ) u_load_ext (
        .i_data   (r_rdata),
        .i_size   (r_size),
        .i_signed (r_signed),
        .o_data   (w_ext_data)
    );

    assign w_drive       = w_in_bus && r_write;
    assign DDT           = w_drive ? w_wdata_bus : {BIT_WIDTH{1'bz}};
    assign bus.req_ready = w_ready;
    assign bus.MREQ      = w_in_bus;
    assign bus.WRITE     = w_in_bus && r_write;
    assign bus.SIZE      = r_size;
    assign bus.DAD       = r_addr;
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_err   = w_rsp_err;
    assign bus.rsp_rdata = ((r_state == ST_DONE) && !r_write) ? w_ext_data : '0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_bus_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_bus_master
//  Purpose  : Self-checking bench with a latency-programmable memory responder
//             and an arithmetic reference model of load/store responses.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmem_bus_master;

    localparam logic [31:0] IDLE_PAT = 32'h5A5A_A5A5;
    localparam int          NEVER    = 100000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        idle_ack = 1'b1;
    wire  [31:0] DDT;

    int n_checks = 0;
    int n_errors = 0;

    // Observations recorded by the access driver
    int          obs_mreq;
    int          obs_rsp_cnt;
    int          obs_rsp_at;
    logic        obs_unstable;
    logic        obs_timeout;
    logic [31:0] obs_dad;
    logic [1:0]  obs_size;
    logic        obs_write;
    logic [31:0] obs_ddt;
    logic [31:0] obs_rdata;
    logic        obs_err;
    logic        obs_ready;
    logic [31:0] obs_ddt_rel;

    dmem_bus_master_if #(.BIT_WIDTH(32)) bus ();

    dmem_bus_master #(
        .BIT_WIDTH      (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .DDT (DDT)
    );

    // Memory side: drives load data during a read cycle, a keeper pattern otherwise
    assign DDT = (bus.MREQ && bus.WRITE) ? 32'hzzzz_zzzz : (bus.MREQ ? mem_rdata : IDLE_PAT);

    always #5 clk = ~clk;

    function automatic logic model_err(input logic [1:0] sz, input logic [31:0] addr);
        if (sz == 2'd0) return (addr % 4) != 0;
        if (sz == 2'd1) return (addr % 2) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_rdata(input logic wr, input logic [1:0] sz,
                                                input logic sg, input logic [31:0] d);
        longint v;
        if (wr) return 32'd0;
        if (sz == 2'd0) return d;
        if (sz == 2'd1) begin
            v = d % 65536;
            if (sg && v >= 32768) v = v - 65536;
        end else begin
            v = d % 256;
            if (sg && v >= 128) v = v - 256;
        end
        return 32'(v);
    endfunction

    function automatic logic [31:0] model_ddt(input logic [1:0] sz, input logic [31:0] wd);
        if (sz == 2'd0) return wd;
        if (sz == 2'd1) return wd % 65536;
        return wd % 256;
    endfunction

    // Presents one request at a negedge, then watches the bus until one cycle after the response
    task automatic do_access(input logic wr, input logic [1:0] sz, input logic sg,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rd, input int lat);
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        mem_rdata      = rd;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        obs_mreq = 0; obs_rsp_cnt = 0; obs_rsp_at = 0; obs_unstable = 1'b0; obs_timeout = 1'b1;
        obs_dad = '0; obs_size = '0; obs_write = 1'b0; obs_ddt = '0;
        obs_rdata = '0; obs_err = 1'b0; obs_ready = 1'b0; obs_ddt_rel = '0;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            if (bus.MREQ) begin
                if (obs_mreq == 0) begin
                    obs_dad = bus.DAD; obs_size = bus.SIZE; obs_write = bus.WRITE; obs_ddt = DDT;
                end else if (bus.DAD !== obs_dad || bus.SIZE !== obs_size ||
                             bus.WRITE !== obs_write || DDT !== obs_ddt) begin
                    obs_unstable = 1'b1;
                end
                obs_mreq++;
            end
            bus.ACKD_n = bus.MREQ ? !(obs_mreq >= lat) : idle_ack;
            if (bus.rsp_valid) begin
                if (obs_rsp_cnt == 0) begin
                    obs_rsp_at = k; obs_rdata = bus.rsp_rdata; obs_err = bus.rsp_err;
                    obs_ready = bus.req_ready; obs_ddt_rel = DDT;
                end
                obs_rsp_cnt++;
            end else if (obs_rsp_cnt != 0) begin
                obs_timeout = 1'b0;
                break;
            end
        end
        bus.ACKD_n = idle_ack;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.MREQ !== 1'b0) begin n_errors++; $display("FAIL reset_mreq: got %b want 0", bus.MREQ); end
        n_checks++; if (bus.WRITE !== 1'b0) begin n_errors++; $display("FAIL reset_write: got %b want 0", bus.WRITE); end
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        n_checks++; if (bus.req_ready !== 1'b1) begin n_errors++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
        n_checks++; if (DDT !== IDLE_PAT) begin n_errors++; $display("FAIL reset_ddt_released: got %h want %h", DDT, IDLE_PAT); end
        n_checks++; if ({bus.DAD, bus.SIZE, bus.rsp_err, bus.rsp_rdata} !== 67'd0) begin
            n_errors++; $display("FAIL reset_outputs_zero: dad %h size %b err %b rdata %h", bus.DAD, bus.SIZE, bus.rsp_err, bus.rsp_rdata);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_word_store();
        do_access(1'b1, 2'b00, 1'b0, 32'h0800_0010, 32'hDEAD_BEEF, 32'h0, 1);
        n_checks++; if (obs_mreq !== 1) begin n_errors++; $display("FAIL wstore_mreq_cycles: got %0d want 1", obs_mreq); end
        n_checks++; if (obs_ddt !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL wstore_ddt: got %h want deadbeef", obs_ddt); end
        n_checks++; if (obs_size !== 2'b00 || obs_write !== 1'b1 || obs_dad !== 32'h0800_0010) begin
            n_errors++; $display("FAIL wstore_ctrl: got size %b write %b dad %h", obs_size, obs_write, obs_dad);
        end
        n_checks++; if (obs_err !== 1'b0 || obs_rsp_cnt !== 1 || obs_rdata !== 32'd0) begin
            n_errors++; $display("FAIL wstore_rsp: got err %b count %0d rdata %h want 0/1/0", obs_err, obs_rsp_cnt, obs_rdata);
        end
        n_checks++; if (obs_rsp_at !== 2 || obs_ready !== 1'b1) begin
            n_errors++; $display("FAIL wstore_latency: got rsp cycle %0d ready %b want 2/1", obs_rsp_at, obs_ready);
        end
        n_checks++; if (obs_ddt_rel !== IDLE_PAT) begin n_errors++; $display("FAIL wstore_ddt_release: got %h want %h", obs_ddt_rel, IDLE_PAT); end
    endtask

    task automatic test_byte_load();
        do_access(1'b0, 2'b10, 1'b1, 32'h0800_0013, 32'h0, 32'h0000_00F0, 1);
        n_checks++; if (obs_rdata !== 32'hFFFF_FFF0 || obs_err !== 1'b0) begin
            n_errors++; $display("FAIL bload_signed: got %h err %b want fffffff0/0", obs_rdata, obs_err);
        end
        do_access(1'b0, 2'b10, 1'b0, 32'h0800_0013, 32'h0, 32'h0000_00F0, 1);
        n_checks++; if (obs_rdata !== 32'h0000_00F0 || obs_err !== 1'b0) begin
            n_errors++; $display("FAIL bload_unsigned: got %h err %b want 000000f0/0", obs_rdata, obs_err);
        end
    endtask

    task automatic test_misaligned();
        do_access(1'b0, 2'b01, 1'b0, 32'h0800_0001, 32'h0, 32'h1234_5678, 1);
        n_checks++; if (obs_err !== 1'b1 || obs_rsp_at !== 1 || obs_rdata !== 32'd0) begin
            n_errors++; $display("FAIL misaligned_rsp: got err %b cycle %0d rdata %h want 1/1/0", obs_err, obs_rsp_at, obs_rdata);
        end
        n_checks++; if (obs_mreq !== 0) begin n_errors++; $display("FAIL misaligned_no_mreq: got %0d cycles want 0", obs_mreq); end
    endtask

    task automatic test_ack_latency();
        do_access(1'b1, 2'b10, 1'b0, 32'hF000_0000, 32'h0000_0041, 32'h0, 3);
        n_checks++; if (obs_mreq !== 3 || obs_unstable !== 1'b0) begin
            n_errors++; $display("FAIL lat3_mreq: got %0d cycles unstable %b want 3/0", obs_mreq, obs_unstable);
        end
        n_checks++; if (obs_ddt !== 32'h0000_0041 || obs_dad !== 32'hF000_0000) begin
            n_errors++; $display("FAIL lat3_bstore: got ddt %h dad %h want 00000041/f0000000", obs_ddt, obs_dad);
        end
        n_checks++; if (obs_rsp_cnt !== 1 || obs_rsp_at !== 4) begin
            n_errors++; $display("FAIL lat3_rsp: got count %0d cycle %0d want 1/4", obs_rsp_cnt, obs_rsp_at);
        end
    endtask

    task automatic test_reset_mid_bus();
        int seen;
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'b00;
        bus.req_signed = 1'b0; bus.req_addr = 32'h0000_0100; bus.ACKD_n = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.MREQ !== 1'b1) begin n_errors++; $display("FAIL midrst_in_bus: got mreq %b want 1", bus.MREQ); end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.MREQ !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            n_errors++; $display("FAIL midrst_abort: got mreq %b rsp %b want 0/0", bus.MREQ, bus.rsp_valid);
        end
        rst = 1'b1; bus.ACKD_n = 1'b0;
        seen = 0;
        repeat (3) begin @(negedge clk); if (bus.rsp_valid || bus.MREQ) seen++; end
        n_checks++; if (seen !== 0) begin n_errors++; $display("FAIL midrst_silent: got %0d active cycles want 0", seen); end
        bus.ACKD_n = 1'b1;
    endtask

`ifdef DMEM_TIMEOUT_EN
    task automatic test_timeout();
        do_access(1'b0, 2'b00, 1'b0, 32'h0000_0200, 32'h0, 32'h0, NEVER);
        n_checks++; if (obs_mreq !== 4 || obs_err !== 1'b1 || obs_rsp_at !== 5) begin
            n_errors++; $display("FAIL timeout: got mreq %0d err %b cycle %0d want 4/1/5", obs_mreq, obs_err, obs_rsp_at);
        end
    endtask
`endif

    task automatic test_random();
        logic        wr, sg, e;
        logic [1:0]  sz;
        logic [31:0] addr, wd, rd;
        int          lat;
        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom_range(0, 1)); sg = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3)); addr = $urandom; wd = $urandom; rd = $urandom;
            lat = $urandom_range(1, 4); idle_ack = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd0) addr = addr - (addr % 4);
                if (sz == 2'd1) addr = addr - (addr % 2);
            end
            e = model_err(sz, addr);
            do_access(wr, sz, sg, addr, wd, rd, lat);
            n_checks++; if (obs_rsp_cnt !== 1 || obs_timeout !== 1'b0) begin
                n_errors++; $display("FAIL rand%0d_rsp_count: got %0d timeout %b want 1/0", i, obs_rsp_cnt, obs_timeout);
            end
            n_checks++; if (obs_err !== e || obs_rdata !== (e ? 32'd0 : model_rdata(wr, sz, sg, rd))) begin
                n_errors++; $display("FAIL rand%0d_rsp: got err %b rdata %h want %b %h", i, obs_err, obs_rdata, e,
                                     e ? 32'd0 : model_rdata(wr, sz, sg, rd));
            end
            n_checks++; if (obs_mreq !== (e ? 0 : lat) || obs_rsp_at !== (e ? 1 : lat + 1) || obs_ready !== 1'b1) begin
                n_errors++; $display("FAIL rand%0d_timing: got mreq %0d cycle %0d ready %b want %0d %0d 1", i, obs_mreq,
                                     obs_rsp_at, obs_ready, e ? 0 : lat, e ? 1 : lat + 1);
            end
            if (!e) begin
                n_checks++; if (obs_dad !== addr || obs_size !== sz || obs_write !== wr || obs_unstable !== 1'b0) begin
                    n_errors++; $display("FAIL rand%0d_bus: got dad %h size %b write %b unstable %b want %h %b %b 0", i,
                                         obs_dad, obs_size, obs_write, obs_unstable, addr, sz, wr);
                end
                if (wr) begin
                    n_checks++; if (obs_ddt !== model_ddt(sz, wd)) begin
                        n_errors++; $display("FAIL rand%0d_ddt: got %h want %h", i, obs_ddt, model_ddt(sz, wd));
                    end
                end
            end
        end
        idle_ack = 1'b1;
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.ACKD_n     = 1'b1;
        @(negedge clk);
        test_reset();
        test_word_store();
        test_byte_load();
        test_misaligned();
        test_ack_latency();
        test_reset_mid_bus();
`ifdef DMEM_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
